// File: rtl/model_memory_write_update.sv
// rtl/model_memory_write_update.sv - DNC memory erase/add update, one element per strobe
// Streams M row-major: M[i][j] <= M[i][j]*(1 - w[i]*e[j]) + w[i]*v[j], fixed point.
module model_memory_write_update #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRACT_SIZE   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 W_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] W_IN,
  output logic                 W_OUT_ENABLE,
  input  logic                 M_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] E_IN,
  input  logic [DATA_SIZE-1:0] V_IN,
  input  logic [DATA_SIZE-1:0] M_IN,
  output logic                 M_IN_READY,
  output logic                 M_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] M_OUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_ELEM,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [CONTROL_SIZE-1:0] C_ZERO = '0;
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic [CONTROL_SIZE-1:0] r_size_n;
  logic [CONTROL_SIZE-1:0] r_size_w;
  logic [CONTROL_SIZE-1:0] r_i;
  logic [CONTROL_SIZE-1:0] r_j;
  logic [DATA_SIZE-1:0]    r_wgt;
  logic [DATA_SIZE-1:0]    r_m_out;
  logic                    r_ready;
  logic                    r_w_out_enable;
  logic                    r_m_in_ready;
  logic                    r_m_out_enable;

  logic [DATA_SIZE-1:0]    w_we;
  logic [DATA_SIZE-1:0]    w_er;
  logic [DATA_SIZE-1:0]    w_ad;
  logic [DATA_SIZE-1:0]    w_res;
  logic [CONTROL_SIZE-1:0] w_n_latch;
  logic [CONTROL_SIZE-1:0] w_w_latch;

  // Signed product at double width; the slice is floor(p / 2^FRACT) truncated.
  function automatic logic [DATA_SIZE-1:0] f_mul(input logic [DATA_SIZE-1:0] a,
                                                 input logic [DATA_SIZE-1:0] b);
    logic [2*DATA_SIZE-1:0] p;
    p = {{DATA_SIZE{a[DATA_SIZE-1]}}, a} * {{DATA_SIZE{b[DATA_SIZE-1]}}, b};
    return p[FRACT_SIZE +: DATA_SIZE];
  endfunction

  assign w_we      = f_mul(r_wgt, E_IN);
  assign w_er      = f_mul(M_IN, w_we);
  assign w_ad      = f_mul(r_wgt, V_IN);
  assign w_res     = M_IN - w_er + w_ad;
  assign w_n_latch = CONTROL_SIZE'(SIZE_N_IN);
  assign w_w_latch = CONTROL_SIZE'(SIZE_W_IN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_size_n       <= '0;
      r_size_w       <= '0;
      r_i            <= '0;
      r_j            <= '0;
      r_wgt          <= '0;
      r_m_out        <= '0;
      r_ready        <= 1'b0;
      r_w_out_enable <= 1'b0;
      r_m_in_ready   <= 1'b0;
      r_m_out_enable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_size_n <= w_n_latch;
            r_size_w <= w_w_latch;
            r_i      <= '0;
            r_j      <= '0;
            if (w_n_latch == C_ZERO || w_w_latch == C_ZERO) begin
              r_state <= S_DONE;
              r_ready <= 1'b1;
            end else begin
              r_state        <= S_ROW;
              r_w_out_enable <= 1'b1;
            end
          end
        end
        S_ROW: begin
          if (W_IN_ENABLE) begin
            r_wgt          <= W_IN;
            r_state        <= S_ELEM;
            r_w_out_enable <= 1'b0;
            r_m_in_ready   <= 1'b1;
          end
        end
        S_ELEM: begin
          if (M_IN_ENABLE) begin
            r_m_out        <= w_res;
            r_state        <= S_OUT;
            r_m_in_ready   <= 1'b0;
            r_m_out_enable <= 1'b1;
          end
        end
        S_OUT: begin
          r_m_out_enable <= 1'b0;
          if (r_j != r_size_w - C_ONE) begin
            r_j          <= r_j + C_ONE;
            r_state      <= S_ELEM;
            r_m_in_ready <= 1'b1;
          end else if (r_i != r_size_n - C_ONE) begin
            r_j            <= '0;
            r_i            <= r_i + C_ONE;
            r_state        <= S_ROW;
            r_w_out_enable <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state        <= S_IDLE;
          r_ready        <= 1'b0;
          r_w_out_enable <= 1'b0;
          r_m_in_ready   <= 1'b0;
          r_m_out_enable <= 1'b0;
        end
      endcase
    end
  end

  assign READY        = r_ready;
  assign W_OUT_ENABLE = r_w_out_enable;
  assign M_IN_READY   = r_m_in_ready;
  assign M_OUT_ENABLE = r_m_out_enable;
  assign M_OUT        = r_m_out;

endmodule
